// File: rtl/mtm_alu_arbiter_if.sv
// mtm_alu_arbiter_if
//   Bundles every bus signal of the ALU-core arbiter: the two requester
//   channels, the core drive/return wires, the response channel and the
//   error counter. The arbiter connects through the slave modport; the
//   requesters/core/consumer side (or a bench) uses the master modport.
//
//   req0_* / req1_* : valid/ready handshake plus operands A, B and ctl byte
//   core_a/b/ctl    : registered drive into the shared core
//   core_c/ctl_out  : core result and status byte
//   rsp_*           : valid/ready response tagged with the requester id
//   err_count       : saturating count of responses with ctl bit 7 set
interface mtm_alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [7:0]  req0_ctl;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [7:0]  req1_ctl;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [7:0]  core_ctl;
    logic [31:0] core_c;
    logic [7:0]  core_ctl_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_c;
    logic [7:0]  rsp_ctl;
    logic [7:0]  err_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctl,
        output req1_ready,
        output core_a, core_b, core_ctl,
        input  core_c, core_ctl_out,
        output rsp_valid, rsp_id, rsp_c, rsp_ctl,
        input  rsp_ready,
        output err_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctl,
        input  req1_ready,
        input  core_a, core_b, core_ctl,
        output core_c, core_ctl_out,
        input  rsp_valid, rsp_id, rsp_c, rsp_ctl,
        output rsp_ready,
        input  err_count
    );
endinterface

// File: rtl/mtm_alu_arbiter.sv
// mtm_alu_arbiter
//   Shares one mtm_Alu_core between two requesters. A round-robin grant
//   picks one operation, the operands are registered onto the core inputs
//   and held for the core latency, the core result is captured and handed
//   out on a single response channel tagged with the requester id.
//   One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous reset, active low
//     bus   : mtm_alu_arbiter_if.slave (requesters, core, response, err_count)
//
//   Parameters:
//     CORE_LAT : core cycles from input sampling edge to valid result (1..4)
//     IDLE_CTL : ctl byte driven to the core while no op is in flight
module mtm_alu_arbiter #(
    parameter int unsigned CORE_LAT = 1,
    parameter logic [7:0]  IDLE_CTL = 8'h20
) (
    input logic              clk,
    input logic              rst_n,
    mtm_alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(CORE_LAT);

    state_t      state_q, state_d;
    logic        last_q, last_d;       // 1: req1 was granted last
    logic [2:0]  lat_q, lat_d;
    logic [31:0] core_a_q, core_a_d;
    logic [31:0] core_b_q, core_b_d;
    logic [7:0]  core_ctl_q, core_ctl_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_c_q, rsp_c_d;
    logic [7:0]  rsp_ctl_q, rsp_ctl_d;
    logic [7:0]  err_q, err_d;

    logic        gnt0, gnt1;
    logic        acc0, acc1;
    logic        rsp_hs;
    logic        lat_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;       // so that req0 wins the first tie
            lat_q       <= 3'd0;
            core_a_q    <= 32'd0;
            core_b_q    <= 32'd0;
            core_ctl_q  <= IDLE_CTL;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= 32'd0;
            rsp_ctl_q   <= 8'd0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lat_q       <= lat_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            core_ctl_q  <= core_ctl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_ctl_q   <= rsp_ctl_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lat_d       = lat_q;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        core_ctl_d  = core_ctl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_ctl_d   = rsp_ctl_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc0 || acc1) begin
                    state_d    = ST_EXEC;
                    last_d     = acc1;
                    lat_d      = LAT_LOAD;
                    core_a_d   = acc1 ? bus.req1_a   : bus.req0_a;
                    core_b_d   = acc1 ? bus.req1_b   : bus.req0_b;
                    core_ctl_d = acc1 ? bus.req1_ctl : bus.req0_ctl;
                    rsp_id_d   = acc1;
                end
            end
            ST_EXEC: begin
                // Counter runs CORE_LAT+1 edges: one for the core to sample,
                // CORE_LAT more for its result to settle on core_c/ctl_out.
                if (lat_done) begin
                    state_d     = ST_RESP;
                    rsp_c_d     = bus.core_c;
                    rsp_ctl_d   = bus.core_ctl_out;
                    rsp_valid_d = 1'b1;
                    core_ctl_d  = IDLE_CTL;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    if (rsp_ctl_q[7]) begin
                        err_d = sat_inc8(err_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        // Tie goes to whoever was not granted last; a lone requester always wins.
        gnt0     = bus.req0_valid && (!bus.req1_valid || last_q);
        gnt1     = bus.req1_valid && (!bus.req0_valid || !last_q);
        acc0     = rst_n && (state_q == ST_IDLE) && gnt0;
        acc1     = rst_n && (state_q == ST_IDLE) && gnt1;
        rsp_hs   = rsp_valid_q && bus.rsp_ready;
        lat_done = (lat_q == 3'd0);

        bus.req0_ready = acc0;
        bus.req1_ready = acc1;
        bus.core_a     = core_a_q;
        bus.core_b     = core_b_q;
        bus.core_ctl   = core_ctl_q;
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_id     = rsp_id_q;
        bus.rsp_c      = rsp_c_q;
        bus.rsp_ctl    = rsp_ctl_q;
        bus.err_count  = err_q;
    end

endmodule
